// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// dmem_arb_pkg : shared types and constants for the data-memory arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int   WORD_BYTES = 4;
  localparam logic P_CPU      = 1'b0;
  localparam logic P_AUX      = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : combinational two-way round-robin picker
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  output logic       o_gnt_valid,
  output logic       o_gnt_idx
);

  always_comb begin
    o_gnt_valid = |i_req;
    o_gnt_idx   = P_CPU;
    if (i_req == 2'b11) begin
      // Under contention the port that did not win last time goes next.
      o_gnt_idx = (i_last_gnt == P_CPU) ? P_AUX : P_CPU;
    end else if (i_req[1]) begin
      o_gnt_idx = P_AUX;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : two-requester round-robin arbiter/sequencer for the data
//                memory; DMEM_ARB_PERF_EN builds the per-port grant counters.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_r,
  output logic              mem_w,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       perf_gnt0,
  output logic [15:0]       perf_gnt1
);

  localparam logic [ADDR_W-1:0] c_MAX_ADDR = ADDR_W'(MEM_BYTES - WORD_BYTES);

  state_e            r_state;
  state_e            w_next;
  logic              r_sel;
  logic              r_we;
  logic              r_err;
  logic              r_last_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_gnt_valid;
  logic              w_gnt_idx;
  logic              w_grant;
  logic              w_req_we;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_wdata;
  logic              w_bad;

  rr_arb2 u_rr_arb2 (
    .i_req       ({req1, req0}),
    .i_last_gnt  (r_last_gnt),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  assign w_grant     = (r_state == IDLE) && w_gnt_valid;
  assign w_req_we    = w_gnt_idx ? we1    : we0;
  assign w_req_addr  = w_gnt_idx ? addr1  : addr0;
  assign w_req_wdata = w_gnt_idx ? wdata1 : wdata0;
  assign w_bad       = (w_req_addr[1:0] != 2'b00) || (w_req_addr > c_MAX_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    mem_r  = 1'b0;
    mem_w  = 1'b0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    err0   = 1'b0;
    err1   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) w_next = w_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_r  = ~r_we;
        mem_w  = r_we;
        w_next = RESP;
      end
      RESP: begin
        ack0   = (r_sel == P_CPU);
        ack1   = (r_sel == P_AUX);
        err0   = (r_sel == P_CPU) && r_err;
        err1   = (r_sel == P_AUX) && r_err;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Address/data registers only move on accepted grants, so the memory bus
  // keeps its last real access while idle or answering a rejected request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= P_CPU;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_last_gnt <= P_AUX;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else if (w_grant) begin
      r_sel      <= w_gnt_idx;
      r_we       <= w_req_we;
      r_err      <= w_bad;
      r_last_gnt <= w_gnt_idx;
      r_rdata    <= '0;
      if (!w_bad) begin
        r_addr  <= w_req_addr;
        r_wdata <= w_req_wdata;
      end
    end else if ((r_state == ACCESS) && !r_we) begin
      r_rdata <= mem_dout;
    end
  end

  assign mem_addr = r_addr;
  assign mem_din  = r_wdata;
  assign rdata    = r_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] r_perf0;
  logic [15:0] r_perf1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf0 <= '0;
      r_perf1 <= '0;
    end else if (w_grant) begin
      if (w_gnt_idx == P_CPU) begin
        if (r_perf0 != 16'hFFFF) r_perf0 <= r_perf0 + 16'd1;
      end else begin
        if (r_perf1 != 16'hFFFF) r_perf1 <= r_perf1 + 16'd1;
      end
    end
  end

  assign perf_gnt0 = r_perf0;
  assign perf_gnt1 = r_perf1;
`else
  assign perf_gnt0 = 16'd0;
  assign perf_gnt1 = 16'd0;
`endif

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressed, little-endian data memory.
- The memory has a combinational read and a posedge write.
- Requester 0 is the CPU load/store stage; requester 1 is the auxiliary port (debug/loader).
- Grants one word access at a time with round-robin fairness, rejects misaligned or out-of-range addresses, and returns read data and an ack pulse.

Parameters:
- ADDR_W, 32, width of requester and memory address buses.
- DATA_W, 32, word width; fixed at 4 bytes.
- MEM_BYTES, 1024, memory size in bytes; valid word addresses are 0 .. MEM_BYTES-4.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  access request, held until the matching ack.
- we0, we1  in  1  1 = store, 0 = load; stable while req is high.
- addr0, addr1  in  ADDR_W  byte address; stable while req is high.
- wdata0, wdata1  in  DATA_W  store data; stable while req is high.
- ack0, ack1  out  1  one-cycle completion pulse.
- err0, err1  out  1  valid with ack; 1 = access rejected.
- rdata  out  DATA_W  load result; valid in the ack cycle.
- mem_addr  out  ADDR_W  to memory address.
- mem_din  out  DATA_W  to memory write data.
- mem_r  out  1  memory read enable.
- mem_w  out  1  memory write enable.
- mem_dout  in  DATA_W  memory read data (combinational).
- perf_gnt0, perf_gnt1  out  16  grant counters (see Optional Feature).

Behaviour:
- Reset (async, while rst_n=0):
  - state=IDLE, last_gnt=1.
  - All outputs 0, including mem_r, mem_w, rdata and the perf counters.
- Reset mid-operation: the access is abandoned immediately and no ack is issued. mem_w drops asynchronously, so no partial write occurs unless the write edge had already passed.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Arbitrate when at least one req is high.
  - If only one is high, grant it.
  - If both are high, grant the port != last_gnt.
  - Latch sel, we, addr and wdata into internal registers; update last_gnt.
  - Check the access:
    - Reject if addr[1:0] != 0 or addr > MEM_BYTES-4; set err_q=1 and go to RESP without any memory access.
    - Otherwise go to ACCESS.
  - With no req high, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr, mem_din = latched wdata.
  - Store: mem_w=1, and the write commits at the posedge ending ACCESS.
  - Load: mem_r=1, and rdata is captured from mem_dout at the posedge ending ACCESS.
  - Always go to RESP.
- RESP (1 cycle):
  - ack[sel]=1 and err[sel]=err_q.
  - rdata is held for loads and is 0 for stores and errors.
  - req is ignored this cycle; go to IDLE.
- Outside ACCESS: mem_r=mem_w=0 and mem_addr/mem_din hold their last value.
- Latency: req sampled in IDLE at cycle N → ack at cycle N+2. Peak throughput is 1 access per 3 cycles.
- Requester rule:
  - At the edge where ack=1 is sampled, the requester drops req or presents a new request.
  - The following IDLE cycle sees the updated inputs; no double-grant is possible.
- Fairness: with both requesting continuously, grants strictly alternate 0,1,0,1…; port 0 wins the first contention after reset.
- Inputs changing while granted are ignored, because the access uses latched values.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - perf_gnt0/perf_gnt1 increment on each IDLE grant to that port, including erroneous grants.
  - The counters saturate at 16'hFFFF and clear only on reset.
- Undefined: counter logic is not built and both outputs are tied to 0.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP}.
  - WORD_BYTES=4.
  - Port index constants P_CPU=0 and P_AUX=1.
- Sub-module rr_arb2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_gnt. Outputs: gnt_valid, gnt_idx.
  - Instantiated once; FSM, latching and checks stay in dmem_arbiter.

Test Plan:
- Single load: req0=1, we0=0, addr0=4, mem holds 0x00000001 at 4 → mem_r=1 in cycle N+1, ack0=1 with rdata=0x00000001 and err0=0 in cycle N+2.
- Store then load: port1 stores 0xDEADBEEF to addr 8, then loads addr 8 → bytes 8..11 = EF,BE,AD,DE and rdata=0xDEADBEEF. Each ack arrives 2 cycles after its IDLE sample.
- Contention: req0 and req1 held high continuously for 4 accesses → grant order 0,1,0,1; acks every 3 cycles; neither port is acked twice in a row.
- Errors: addr0=6 → ack0=1, err0=1, mem_r and mem_w never asserted. Same for addr1=1021 (> 1020). addr=1020 is accepted with err=0.
- Reset mid-store: rst_n low during ACCESS before the posedge → mem_w falls to 0 immediately, memory is unchanged, and no ack occurs. After release, port 0 wins the first contention.
- Perf (with DMEM_ARB_PERF_EN): 5 grants to port 0 and 3 to port 1 → perf_gnt0=5, perf_gnt1=3. Without the macro, both read 0.
